// File: rtl/cart_mem_arb.sv
// cart_mem_arb: shares the cartridge ROM SDRAM request port between download writes
// (one-byte buffer) and Z80 cartridge reads (one-entry read cache, WAIT stretching).
// state | meaning
// IDLE  | nothing outstanding; a read miss wins over a buffered write
// RD    | CPU read miss in flight
// WR    | buffered download byte in flight
module cart_mem_arb #(
  parameter int ADDR_W = 25
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_ioctl_wr,
  input  logic [ADDR_W-1:0] i_ioctl_addr,
  input  logic [7:0]        i_ioctl_dout,
  input  logic              i_ioctl_isROM,
  output logic              o_ioctl_wait,
  input  logic              i_cpu_rd,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  output logic [7:0]        o_cpu_dout,
  output logic              o_cpu_wait_n,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_din,
  input  logic              i_mem_ack,
  input  logic [7:0]        i_mem_dout
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_cpu_rd_q;
  logic              r_rd_pend;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_wbuf_full;
  logic [ADDR_W-1:0] r_wbuf_addr;
  logic [7:0]        r_wbuf_data;
  logic              r_cache_valid;
  logic [ADDR_W-1:0] r_cache_addr;
  logic [7:0]        r_cache_data;
  logic [7:0]        r_cpu_dout;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_din;

  logic              w_rd_edge;
  logic              w_hit;
  logic              w_rd_miss;
  logic              w_rd_req;
  logic              w_wr_accept;
  logic              w_rd_done;
  logic              w_wr_done;
  logic              w_issue;
  logic              w_issue_wr;
  logic [ADDR_W-1:0] w_rd_issue_addr;

  assign w_rd_edge   = i_cpu_rd & ~r_cpu_rd_q;
  assign w_hit       = r_cache_valid & (i_cpu_addr == r_cache_addr);
  assign w_rd_miss   = w_rd_edge & ~w_hit;
  // A fresh miss is issued straight from IDLE so mem_req rises one cycle after the edge.
  assign w_rd_req    = r_rd_pend | w_rd_miss;
  assign w_wr_accept = i_ioctl_wr & i_ioctl_isROM & ~r_wbuf_full;
  assign w_rd_done   = (r_state == S_RD) & i_mem_ack;
  assign w_wr_done   = (r_state == S_WR) & i_mem_ack;
  assign w_issue     = (r_state == S_IDLE) & (w_state_nxt != S_IDLE);
  assign w_issue_wr  = w_issue & (w_state_nxt == S_WR);
  assign w_rd_issue_addr = r_rd_pend ? r_rd_addr : i_cpu_addr;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_rd_req)         w_state_nxt = S_RD;
        else if (r_wbuf_full) w_state_nxt = S_WR;
      end
      S_RD:    if (i_mem_ack) w_state_nxt = S_IDLE;
      S_WR:    if (i_mem_ack) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cpu_rd_q    <= 1'b0;
      r_rd_pend     <= 1'b0;
      r_rd_addr     <= '0;
      r_wbuf_full   <= 1'b0;
      r_wbuf_addr   <= '0;
      r_wbuf_data   <= 8'h00;
      r_cache_valid <= 1'b0;
      r_cache_addr  <= '0;
      r_cache_data  <= 8'h00;
      r_cpu_dout    <= 8'hFF;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_din     <= 8'h00;
    end else begin
      r_cpu_rd_q <= i_cpu_rd;

      if (w_wr_accept) begin
        r_wbuf_full <= 1'b1;
        r_wbuf_addr <= i_ioctl_addr;
        r_wbuf_data <= i_ioctl_dout;
      end else if (w_wr_done) begin
        r_wbuf_full <= 1'b0;
      end

      if (w_rd_done) r_rd_pend <= 1'b0;
      if (w_rd_miss && (!r_rd_pend || w_rd_done)) begin
        r_rd_pend <= 1'b1;
        r_rd_addr <= i_cpu_addr;
      end

      if (w_rd_done)               r_cpu_dout <= i_mem_dout;
      else if (w_rd_edge && w_hit) r_cpu_dout <= r_cache_data;

      if (w_rd_done) begin
        r_cache_valid <= 1'b1;
        r_cache_addr  <= r_mem_addr;
        r_cache_data  <= i_mem_dout;
      end else if (w_issue_wr) begin
        r_cache_valid <= 1'b0;
      end

      if (w_issue) begin
        r_mem_req  <= 1'b1;
        r_mem_we   <= w_issue_wr;
        r_mem_addr <= w_issue_wr ? r_wbuf_addr : w_rd_issue_addr;
        if (w_issue_wr) r_mem_din <= r_wbuf_data;
      end else if ((r_state != S_IDLE) && i_mem_ack) begin
        r_mem_req <= 1'b0;
      end
    end
  end

  assign o_ioctl_wait = r_wbuf_full;
  assign o_cpu_wait_n = ~w_rd_miss & ~r_rd_pend;
  assign o_cpu_dout   = r_cpu_dout;
  assign o_mem_req    = r_mem_req;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_din    = r_mem_din;

endmodule

// File: tb/tb_cart_mem_arb.sv
// Directed bench for cart_mem_arb: a memory responder with programmable ack latency
// logs every request; each test task checks its own expected values inline.
module tb_cart_mem_arb;
  localparam int ADDR_W = 25;

  logic              clk;
  logic              reset;
  logic              ioctl_wr;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_isROM;
  logic              ioctl_wait;
  logic              cpu_rd;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_dout;
  logic              cpu_wait_n;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic              mem_ack;
  logic [7:0]        mem_dout;

  int checks = 0;
  int errors = 0;

  int                lat;
  logic [7:0]        rd_data;
  int                age;
  int                nreq;
  int                stab_err;
  logic              prev_req;
  logic              log_we   [64];
  logic [ADDR_W-1:0] log_addr [64];
  logic [7:0]        log_din  [64];
  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [7:0]        cur_din;

  cart_mem_arb #(.ADDR_W(ADDR_W)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_ioctl_wr(ioctl_wr), .i_ioctl_addr(ioctl_addr), .i_ioctl_dout(ioctl_dout),
    .i_ioctl_isROM(ioctl_isROM), .o_ioctl_wait(ioctl_wait),
    .i_cpu_rd(cpu_rd), .i_cpu_addr(cpu_addr), .o_cpu_dout(cpu_dout),
    .o_cpu_wait_n(cpu_wait_n),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_din(mem_din),
    .i_mem_ack(mem_ack), .i_mem_dout(mem_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory responder: acks `lat` cycles after mem_req is first seen high.
  initial begin
    mem_ack = 1'b0; mem_dout = 8'h00; age = 0; nreq = 0; stab_err = 0; prev_req = 1'b0;
    cur_we = 1'b0; cur_addr = '0; cur_din = 8'h00;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (reset) begin
        age = 0;
        prev_req = 1'b0;
      end else begin
        if (mem_req && !prev_req) begin
          if (nreq < 64) begin
            log_we[nreq] = mem_we; log_addr[nreq] = mem_addr; log_din[nreq] = mem_din;
          end
          nreq++;
          cur_we = mem_we; cur_addr = mem_addr; cur_din = mem_din;
        end else if (mem_req && (mem_we !== cur_we || mem_addr !== cur_addr ||
                                 (mem_we && mem_din !== cur_din))) begin
          stab_err++;
        end
        if (mem_req) begin
          if (age == lat) begin
            mem_ack = 1'b1; mem_dout = rd_data; age = 0;
          end else begin
            age++;
          end
        end else begin
          age = 0;
        end
        prev_req = mem_req;
      end
    end
  end

  task automatic step();
    @(posedge clk); #3;
  endtask

  // Full Z80 read; returns WAIT level in the first cycle and cycles spent with WAIT low.
  task automatic run_read(input logic [ADDR_W-1:0] a, output logic first_wn, output int waited);
    int n;
    step();
    cpu_addr = a; cpu_rd = 1'b1;
    #1;
    first_wn = cpu_wait_n;
    n = 0;
    while (!cpu_wait_n && n < 40) begin
      step(); n++;
    end
    waited = cpu_wait_n ? n : -1;
    step();
    cpu_rd = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL reset_ioctl_wait: got %b want 0", ioctl_wait); end
    checks++; if (cpu_wait_n !== 1'b1) begin errors++; $display("FAIL reset_cpu_wait_n: got %b want 1", cpu_wait_n); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL reset_mem_din: got %h want 00", mem_din); end
    checks++; if (cpu_dout !== 8'hFF) begin errors++; $display("FAIL reset_cpu_dout: got %h want FF", cpu_dout); end
    reset = 1'b0;
  endtask

  task automatic test_download();
    int base;
    logic exp_wait;
    base = nreq; lat = 3;
    for (int i = 0; i < 4; i++) begin
      step();
      ioctl_wr = 1'b1; ioctl_isROM = 1'b1;
      ioctl_addr = ADDR_W'(i); ioctl_dout = 8'hA0 + 8'(i);
      for (int k = 1; k <= 7; k++) begin
        step();
        ioctl_wr = 1'b0;
        exp_wait = (k <= 5);
        checks++; if (ioctl_wait !== exp_wait) begin errors++; $display("FAIL dl_ioctl_wait[%0d] cyc %0d: got %b want %b", i, k, ioctl_wait, exp_wait); end
      end
    end
    checks++; if (nreq !== base + 4) begin errors++; $display("FAIL dl_count: got %0d want %0d", nreq - base, 4); end
    for (int i = 0; i < 4; i++) begin
      if (base + i < 64) begin
        checks++;
        if (log_we[base+i] !== 1'b1 || log_addr[base+i] !== ADDR_W'(i) || log_din[base+i] !== 8'hA0 + 8'(i)) begin
          errors++;
          $display("FAIL dl_write[%0d]: got we=%b addr=%h din=%h want we=1 addr=%h din=%h",
                   i, log_we[base+i], log_addr[base+i], log_din[base+i], ADDR_W'(i), 8'hA0 + 8'(i));
        end
      end
    end
    step();
    ioctl_wr = 1'b1; ioctl_isROM = 1'b0; ioctl_addr = 'h9; ioctl_dout = 8'h55;
    step();
    ioctl_wr = 1'b0; ioctl_isROM = 1'b1;
    checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL dl_notrom_wait: got %b want 0", ioctl_wait); end
    repeat (6) step();
    checks++; if (nreq !== base + 4) begin errors++; $display("FAIL dl_notrom_access: got %0d want %0d", nreq - base, 4); end
  endtask

  task automatic test_read_miss_hit();
    int base, w;
    logic fw, exp_wn;
    base = nreq; lat = 4; rd_data = 8'h5A;
    step();
    cpu_addr = 'h0123; cpu_rd = 1'b1;
    #1;
    checks++; if (cpu_wait_n !== 1'b0) begin errors++; $display("FAIL miss_wait_first: got %b want 0", cpu_wait_n); end
    for (int k = 1; k <= 6; k++) begin
      step();
      exp_wn = (k == 6);
      checks++; if (cpu_wait_n !== exp_wn) begin errors++; $display("FAIL miss_wait cyc %0d: got %b want %b", k, cpu_wait_n, exp_wn); end
      if (k == 1) begin
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 'h0123) begin
          errors++; $display("FAIL miss_req: got req=%b we=%b addr=%h want req=1 we=0 addr=0123", mem_req, mem_we, mem_addr);
        end
      end
    end
    checks++; if (cpu_dout !== 8'h5A) begin errors++; $display("FAIL miss_dout: got %h want 5A", cpu_dout); end
    checks++; if (nreq !== base + 1) begin errors++; $display("FAIL miss_count: got %0d want 1", nreq - base); end
    cpu_rd = 1'b0;
    step(); step();
    rd_data = 8'h00;
    run_read('h0123, fw, w);
    checks++; if (fw !== 1'b1) begin errors++; $display("FAIL hit_wait_first: got %b want 1", fw); end
    checks++; if (w !== 0) begin errors++; $display("FAIL hit_wait_cycles: got %0d want 0", w); end
    checks++; if (cpu_dout !== 8'h5A) begin errors++; $display("FAIL hit_dout: got %h want 5A", cpu_dout); end
    repeat (3) step();
    checks++; if (nreq !== base + 1) begin errors++; $display("FAIL hit_no_access: got %0d want 1", nreq - base); end
  endtask

  task automatic test_priority_collision();
    int base, w;
    logic fw;
    base = nreq; lat = 3; rd_data = 8'h3C;
    step();
    ioctl_wr = 1'b1; ioctl_isROM = 1'b1; ioctl_addr = 'h0123; ioctl_dout = 8'h77;
    cpu_rd = 1'b1; cpu_addr = 'h0200;
    #1;
    checks++; if (cpu_wait_n !== 1'b0) begin errors++; $display("FAIL col_wait_first: got %b want 0", cpu_wait_n); end
    step();
    ioctl_wr = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 'h0200 || ioctl_wait !== 1'b1) begin
      errors++; $display("FAIL col_read_first: got req=%b we=%b addr=%h wait=%b want req=1 we=0 addr=0200 wait=1",
                         mem_req, mem_we, mem_addr, ioctl_wait);
    end
    repeat (4) step();
    checks++;
    if (cpu_wait_n !== 1'b1 || cpu_dout !== 8'h3C || mem_req !== 1'b0) begin
      errors++; $display("FAIL col_read_done: got wait_n=%b dout=%h req=%b want 1 3C 0", cpu_wait_n, cpu_dout, mem_req);
    end
    cpu_rd = 1'b0;
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 'h0123 || mem_din !== 8'h77) begin
      errors++; $display("FAIL col_write_second: got req=%b we=%b addr=%h din=%h want 1 1 0123 77",
                         mem_req, mem_we, mem_addr, mem_din);
    end
    repeat (4) step();
    checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL col_write_done: got wait=%b want 0", ioctl_wait); end
    checks++; if (nreq !== base + 2) begin errors++; $display("FAIL col_count: got %0d want 2", nreq - base); end
    if (base + 1 < 64) begin
      checks++;
      if (log_we[base] !== 1'b0 || log_addr[base] !== 'h0200 || log_we[base+1] !== 1'b1 || log_addr[base+1] !== 'h0123) begin
        errors++; $display("FAIL col_order: got %b/%h then %b/%h want 0/0200 then 1/0123",
                           log_we[base], log_addr[base], log_we[base+1], log_addr[base+1]);
      end
    end
    run_read('h0200, fw, w);
    checks++; if (fw !== 1'b0 || w !== 5) begin errors++; $display("FAIL col_reread_0200: got wait_first=%b cycles=%0d want 0 5", fw, w); end
    checks++; if (cpu_dout !== 8'h3C) begin errors++; $display("FAIL col_reread_0200_dout: got %h want 3C", cpu_dout); end
    rd_data = 8'h77;
    run_read('h0123, fw, w);
    checks++; if (fw !== 1'b0 || w !== 5) begin errors++; $display("FAIL col_read_0123: got wait_first=%b cycles=%0d want 0 5", fw, w); end
    checks++; if (cpu_dout !== 8'h77) begin errors++; $display("FAIL col_read_0123_dout: got %h want 77", cpu_dout); end
    checks++; if (nreq !== base + 4) begin errors++; $display("FAIL col_total: got %0d want 4", nreq - base); end
  endtask

  task automatic test_overrun();
    int base;
    base = nreq; lat = 3;
    step();
    ioctl_wr = 1'b1; ioctl_isROM = 1'b1; ioctl_addr = 'h10; ioctl_dout = 8'h11;
    step();
    checks++; if (ioctl_wait !== 1'b1) begin errors++; $display("FAIL ovr_wait: got %b want 1", ioctl_wait); end
    ioctl_addr = 'h11; ioctl_dout = 8'h22;
    step();
    ioctl_wr = 1'b0;
    repeat (7) step();
    checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL ovr_wait_clear: got %b want 0", ioctl_wait); end
    checks++; if (nreq !== base + 1) begin errors++; $display("FAIL ovr_count: got %0d want 1", nreq - base); end
    if (base < 64) begin
      checks++;
      if (log_we[base] !== 1'b1 || log_addr[base] !== 'h10 || log_din[base] !== 8'h11) begin
        errors++; $display("FAIL ovr_write: got we=%b addr=%h din=%h want 1 10 11", log_we[base], log_addr[base], log_din[base]);
      end
    end
  endtask

  task automatic test_read_abandon();
    int base, w;
    logic fw;
    base = nreq; lat = 4; rd_data = 8'hC3;
    step();
    cpu_rd = 1'b1; cpu_addr = 'h0345;
    step();
    cpu_rd = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 'h0345 || cpu_wait_n !== 1'b0) begin
      errors++; $display("FAIL abn_req: got req=%b addr=%h wait_n=%b want 1 0345 0", mem_req, mem_addr, cpu_wait_n);
    end
    repeat (5) step();
    checks++;
    if (mem_req !== 1'b0 || cpu_wait_n !== 1'b1 || cpu_dout !== 8'hC3) begin
      errors++; $display("FAIL abn_done: got req=%b wait_n=%b dout=%h want 0 1 C3", mem_req, cpu_wait_n, cpu_dout);
    end
    repeat (3) step();
    checks++; if (nreq !== base + 1) begin errors++; $display("FAIL abn_count: got %0d want 1", nreq - base); end
    rd_data = 8'h00;
    run_read('h0345, fw, w);
    checks++; if (fw !== 1'b1 || w !== 0) begin errors++; $display("FAIL abn_cache_hit: got wait_first=%b cycles=%0d want 1 0", fw, w); end
    checks++; if (cpu_dout !== 8'hC3 || nreq !== base + 1) begin errors++; $display("FAIL abn_hit_data: got dout=%h n=%0d want C3 1", cpu_dout, nreq - base); end
  endtask

  task automatic test_reset_mid_rd();
    int base, w;
    logic fw;
    lat = 6; rd_data = 8'h9E;
    step();
    cpu_rd = 1'b1; cpu_addr = 'h0400;
    step();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_rd_req: got %b want 1", mem_req); end
    base = nreq;
    step();
    reset = 1'b1; cpu_rd = 1'b0;
    step();
    checks++;
    if (mem_req !== 1'b0 || cpu_wait_n !== 1'b1 || cpu_dout !== 8'hFF || ioctl_wait !== 1'b0) begin
      errors++; $display("FAIL rst_mid_rd: got req=%b wait_n=%b dout=%h iowait=%b want 0 1 FF 0",
                         mem_req, cpu_wait_n, cpu_dout, ioctl_wait);
    end
    step();
    reset = 1'b0;
    repeat (8) step();
    checks++; if (nreq !== base) begin errors++; $display("FAIL rst_no_request: got %0d want 0", nreq - base); end
    run_read('h0345, fw, w);
    checks++; if (fw !== 1'b0 || w !== 8) begin errors++; $display("FAIL rst_cache_cleared: got wait_first=%b cycles=%0d want 0 8", fw, w); end
    checks++; if (cpu_dout !== 8'h9E) begin errors++; $display("FAIL rst_reread_dout: got %h want 9E", cpu_dout); end
  endtask

  task automatic test_stability();
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL mem_stable: got %0d changes want 0", stab_err); end
  endtask

  initial begin
    lat = 3; rd_data = 8'h00;
    reset = 1'b1; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = 8'h00; ioctl_isROM = 1'b1;
    cpu_rd = 1'b0; cpu_addr = '0;
    test_reset();
    test_download();
    test_read_miss_hit();
    test_priority_collision();
    test_overrun();
    test_read_abandon();
    test_reset_mid_rd();
    test_stability();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cart_mem_arb.md
# cart_mem_arb

Single-port arbiter sequencing the cartridge ROM backing store (SDRAM controller request port) between two requesters: the host ROM-download write stream (ioctl) and Z80 cartridge-slot reads. Sits between the cartridge slot logic / ioctl bus and the SDRAM controller. It buffers one download byte and drives `ioctl_wait`. It stretches Z80 cycles through `cpu_wait_n` on read misses, and keeps a one-entry read cache so repeated fetches of the same byte cost no SDRAM access.

## Interface
- `ADDR_W`, 25, byte address width for ioctl, CPU and memory ports.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ioctl_wr`  in  1  one-cycle download write strobe.
- `ioctl_addr`  in  ADDR_W  download byte address.
- `ioctl_dout`  in  8  download byte.
- `ioctl_isROM`  in  1  download targets cartridge ROM; strobes are ignored when low.
- `ioctl_wait`  out  1  write buffer occupied; host must not strobe while high.
- `cpu_rd`  in  1  level, high for the whole Z80 cartridge read (slot-qualified MREQ & RD).
- `cpu_addr`  in  ADDR_W  mapped ROM byte address, stable while `cpu_rd` is high.
- `cpu_dout`  out  8  read data to the CPU mux.
- `cpu_wait_n`  out  1  Z80 WAIT, active low.
- `mem_req`  out  1  memory request, held until acknowledged.
- `mem_we`  out  1  1 = write, 0 = read; stable while `mem_req` is high.
- `mem_addr`  out  ADDR_W  memory address; stable while `mem_req` is high.
- `mem_din`  out  8  write data.
- `mem_ack`  in  1  one-cycle completion pulse; read data is valid in the same cycle.
- `mem_dout`  in  8  read data.

## Operation
- Write buffer (1 entry): an accepted `ioctl_wr` (with `ioctl_isROM` = 1) captures addr and data and sets `wbuf_full`.
  - `ioctl_wait` = `wbuf_full`, registered.
  - A strobe arriving while `wbuf_full` = 1 is dropped; the buffer contents are unchanged.
- Read cache (1 entry): `cache_valid`, `cache_addr`, `cache_data`.
  - Any write issued to memory clears `cache_valid` in the cycle its `mem_req` rises.
- Read detection: `rd_edge` = `cpu_rd` & ~`cpu_rd_q`.
  - Hit: `cache_valid` and `cpu_addr` == `cache_addr`. `cpu_dout` <= `cache_data` on the next edge; no wait.
  - Miss: sets `rd_pend` and latches `cpu_addr`.
- `cpu_wait_n` = ~(`rd_edge` & miss) & ~`rd_pend`. It is combinationally low from the first miss cycle and stays low until `rd_pend` clears.
- FSM states: IDLE, RD, WR.
  - IDLE -> RD when `rd_pend` = 1. CPU reads take priority over writes.
  - IDLE -> WR when `wbuf_full` = 1 and `rd_pend` = 0.
  - RD: `mem_req` = 1, `mem_we` = 0, `mem_addr` = latched address. On `mem_ack`: `cpu_dout` and `cache_data` <= `mem_dout`, `cache_addr` <= latched address, `cache_valid` <= 1, `rd_pend` <= 0, -> IDLE.
  - WR: `mem_req` = 1, `mem_we` = 1, buffered addr and data. On `mem_ack`: `wbuf_full` <= 0, -> IDLE.
- No new request is issued in the cycle of `mem_ack`; IDLE always occupies at least one cycle.
- A new `ioctl_wr` may be accepted in the cycle after `wbuf_full` clears.
- `cpu_rd` dropping while RD is in flight: the access completes and fills the cache; `cpu_dout` is still updated.
- Simultaneous `rd_edge` miss and `ioctl_wr`: both are captured. The read is serviced first, then the write, and the write invalidates the cache.

## Timing
- Reset values:
  - `ioctl_wait` = 0, `cpu_wait_n` = 1, `mem_req` = 0, `mem_we` = 0.
  - `mem_addr` = 0, `mem_din` = 0, `cpu_dout` = 8'hFF.
  - FSM = IDLE, `cache_valid` = 0, `wbuf_full` = 0, `rd_pend` = 0.
- Reset mid-transaction drops `mem_req` on the next edge; the memory controller must tolerate an abandoned request.
- Hit latency: `cpu_dout` is valid 1 cycle after `rd_edge`.
- Miss latency: `mem_req` rises 1 cycle after `rd_edge` if IDLE, else 1 cycle after the current access's ack plus 1. `cpu_wait_n` returns high the cycle after `mem_ack`.
- `mem_req`, `mem_we`, `mem_addr` and `mem_din` are registered and held constant until `mem_ack`.

## Test plan
- Reset: assert `reset` for 2 cycles mid-RD. Required: `mem_req` = 0 and `cpu_wait_n` = 1 on the next edge, `cpu_dout` = FF.
- Download: 4 strobes 8 cycles apart, addr 0..3, data A0..A3, `mem_ack` 3 cycles after req.
  - Required: 4 writes in order with correct addr and data.
  - `ioctl_wait` high from the strobe until the ack, then low.
  - A strobe with `ioctl_isROM` = 0 produces no access.
- Read miss then hit: `cpu_rd` at 0x0123, memory returns 5A after 4 cycles.
  - Required: `cpu_wait_n` low from the first cycle until the cycle after ack; `cpu_dout` = 5A.
  - Second `cpu_rd` at 0x0123: no `mem_req`, `cpu_wait_n` stays 1, `cpu_dout` = 5A after 1 cycle.
- Priority collision: `ioctl_wr` (addr 0x0123, data 77) in the same cycle as a read miss at 0x0200.
  - Required: read issued first, then the write.
  - Subsequent read at 0x0123 misses, and 0x0200 misses again (cache invalidated).
- Overrun: a second `ioctl_wr` while `ioctl_wait` = 1. Required: dropped; only the first byte is written.
- Read abandoned: `cpu_rd` falls 1 cycle after a miss. Required: RD completes, cache filled, FSM returns to IDLE, no extra request.
